// File: rtl/key_irq_queue.sv
`default_nettype none
// ============================================================================
// Module      : key_irq_queue
// Description : Queues keyboard scancodes and presents them one at a time to a
//               CPU as a level interrupt. Each scancode is held on intData with
//               irq high until the CPU acknowledges it. A guaranteed irq-low gap
//               follows every acknowledge before the next code is presented.
//
// Ports       : clk          - single clock, all state changes on rising edge
//               rst          - asynchronous active-low reset
//               pressedKey   - 9-bit scancode from the keyboard reader
//               pressed      - key-valid level; only rising edges push
//               enable       - capture enable; gates pushes only
//               ack          - interrupt acknowledge level; only rising edges pop
//               clrOverflow  - clears the sticky overflow flag
//               irq          - interrupt request, high while a code is presented
//               intData      - presented scancode, zero-extended to 16 bits
//               count        - current FIFO occupancy
//               overflow     - sticky flag, set when a key is dropped on full
//
// Revision    : 1.0 - initial release
// ============================================================================
module key_irq_queue #(
  parameter int DEPTH      = 8,
  parameter int GAP_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [8:0]               pressedKey,
  input  logic                     pressed,
  input  logic                     enable,
  input  logic                     ack,
  input  logic                     clrOverflow,
  output logic                     irq,
  output logic [15:0]              intData,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_CW = c_AW + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRESENT = 2'd1,
    S_GAP     = 2'd2
  } state_t;

  // Storage and pointers
  logic [8:0]      r_mem [DEPTH];
  logic [c_AW-1:0] r_wr_ptr;
  logic [c_AW-1:0] r_rd_ptr;
  logic [c_CW-1:0] r_count;
  logic            r_ovf;

  // Edge detectors: pressedPrev resets high so a key held through reset
  // release is not mistaken for a new press.
  logic            r_pressed_prev;
  logic            r_ack_prev;

  // Presentation state
  state_t          r_state;
  state_t          w_state_nxt;
  logic [3:0]      r_gap_cnt;
  logic [3:0]      w_gap_nxt;
  logic [15:0]     r_int_data;
  logic            w_load;
  logic            w_pop;

  logic            w_push_ev;
  logic            w_ack_ev;
  logic            w_full;
  logic            w_do_push;
  logic            w_drop;
  logic [8:0]      w_head;

  assign w_push_ev = enable & pressed & ~r_pressed_prev;
  assign w_ack_ev  = ack & ~r_ack_prev;
  // Fullness is taken from the registered count, i.e. before any pop that
  // happens on the same edge, so a push into a full queue always drops.
  assign w_full    = (r_count == c_CW'(DEPTH));
  assign w_do_push = w_push_ev & ~w_full;
  assign w_drop    = w_push_ev & w_full;
  assign w_head    = r_mem[r_rd_ptr];

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next-state and control
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_gap_nxt   = r_gap_cnt;
    w_load      = 1'b0;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_count != '0) begin
          w_load      = 1'b1;
          w_state_nxt = S_PRESENT;
        end
      end
      S_PRESENT: begin
        if (w_ack_ev) begin
          w_pop       = 1'b1;
          w_gap_nxt   = 4'(GAP_CYCLES);
          w_state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        // The counter is loaded with GAP_CYCLES on the acknowledge edge; leaving
        // on the edge where it would reach zero gives exactly GAP_CYCLES low
        // cycles of irq.
        if (r_gap_cnt > 4'd1) begin
          w_gap_nxt = r_gap_cnt - 4'd1;
        end else begin
          w_gap_nxt = 4'd0;
          if (r_count != '0) begin
            w_load      = 1'b1;
            w_state_nxt = S_PRESENT;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_gap_nxt   = 4'd0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_gap_cnt      <= 4'd0;
      r_int_data     <= 16'd0;
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_ovf          <= 1'b0;
      r_pressed_prev <= 1'b1;
      r_ack_prev     <= 1'b0;
    end else begin
      r_gap_cnt      <= w_gap_nxt;
      r_pressed_prev <= pressed;
      r_ack_prev     <= ack;

      if (w_load) begin
        r_int_data <= {7'd0, w_head};
      end

      // Pointers are DEPTH-sized (power of two) so they wrap naturally.
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + c_AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_AW'(1);
      end

      case ({w_do_push, w_pop})
        2'b10:   r_count <= r_count + c_CW'(1);
        2'b01:   r_count <= r_count - c_CW'(1);
        default: r_count <= r_count;
      endcase

      // A drop on the same edge as a clear wins.
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (clrOverflow) begin
        r_ovf <= 1'b0;
      end
    end
  end

  // Entry storage needs no reset: contents are only read behind a valid count.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= pressedKey;
    end
  end

  assign irq      = (r_state == S_PRESENT);
  assign intData  = r_int_data;
  assign count    = r_count;
  assign overflow = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_key_irq_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_irq_queue
// Description : Self-checking bench for key_irq_queue. A queue-based reference
//               model tracks stored codes, the presented code and the earliest
//               edge at which a new presentation may begin.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_irq_queue;

  localparam int DEPTH = 8;
  localparam int GAP   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [8:0]  pressedKey;
  logic        pressed;
  logic        enable;
  logic        ack;
  logic        clrOverflow;
  logic        irq;
  logic [15:0] intData;
  logic [3:0]  count;
  logic        overflow;

  always #5 clk = ~clk;

  key_irq_queue #(.DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
    .clk        (clk),
    .rst        (rst),
    .pressedKey (pressedKey),
    .pressed    (pressed),
    .enable     (enable),
    .ack        (ack),
    .clrOverflow(clrOverflow),
    .irq        (irq),
    .intData    (intData),
    .count      (count),
    .overflow   (overflow)
  );

  int checks = 0;
  int errors = 0;

  // Reference model
  logic [8:0]  q[$];
  bit          m_pres;
  logic [15:0] m_data;
  bit          m_ovf;
  bit          m_pp;
  bit          m_ap;
  int          cyc = 0;
  int          m_free;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_pres = 1'b0;
    m_data = 16'd0;
    m_ovf  = 1'b0;
    m_pp   = 1'b1;
    m_ap   = 1'b0;
    m_free = 0;
  endtask

  // One rising edge of the reference model, using inputs as sampled at the edge.
  task automatic model_edge();
    bit push_ev, ack_ev, full, drop;
    int size0;
    push_ev = enable && pressed && !m_pp;
    ack_ev  = ack && !m_ap;
    size0   = q.size();
    full    = (size0 == DEPTH);
    drop    = 1'b0;
    if (m_pres && ack_ev) begin
      void'(q.pop_front());
      m_pres = 1'b0;
      m_free = cyc + GAP;
    end else if (!m_pres && cyc >= m_free && size0 > 0) begin
      m_pres = 1'b1;
      m_data = {7'd0, q[0]};
    end
    if (push_ev) begin
      if (full) drop = 1'b1;
      else      q.push_back(pressedKey);
    end
    if (drop)             m_ovf = 1'b1;
    else if (clrOverflow) m_ovf = 1'b0;
    m_pp = pressed;
    m_ap = ack;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".irq"},      32'(irq),      32'(m_pres));
    chk({tag, ".intData"},  32'(intData),  32'(m_data));
    chk({tag, ".count"},    32'(count),    32'(q.size()));
    chk({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_edge();
    cyc++;
    @(negedge clk);
    check_outputs("cyc");
  endtask

  task automatic push_pulse(input logic [8:0] code);
    pressedKey = code;
    pressed    = 1'b1;
    tick();
    pressed    = 1'b0;
    tick();
  endtask

  task automatic ack_pulse();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  task automatic wait_irq(input string tag);
    int n = 0;
    while (!m_pres && n < 100) begin
      tick();
      n++;
    end
    chk({tag, ".irq_seen"}, 32'(irq), 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() > 0 || m_pres) && n < 400) begin
      if (m_pres) ack_pulse();
      else        tick();
      n++;
    end
    repeat (GAP + 2) tick();
  endtask

  task automatic low_gap(input string tag);
    int n = 0;
    while (irq === 1'b0 && n < 50) begin
      n++;
      tick();
    end
    chk({tag, ".gap"}, 32'(n), 32'(GAP));
  endtask

  initial begin
    rst         = 1'b0;
    pressed     = 1'b1;
    pressedKey  = 9'h0AA;
    enable      = 1'b1;
    ack         = 1'b0;
    clrOverflow = 1'b0;
    model_reset();
    #1;
    check_outputs("reset");
    repeat (3) tick();

    // Release with pressed still high: no push must follow.
    rst = 1'b1;
    repeat (3) tick();
    chk("held_over_reset.count", 32'(count), 32'd0);
    pressed = 1'b0;
    tick();

    // Basic single key
    push_pulse(9'h01C);
    chk("basic.irq", 32'(irq), 32'd1);
    chk("basic.data", 32'(intData), 32'h001C);
    ack_pulse();
    chk("basic.irq_drop", 32'(irq), 32'd0);
    chk("basic.count", 32'(count), 32'd0);
    repeat (4) tick();

    // Back-to-back presentations with exact gap
    push_pulse(9'h011);
    push_pulse(9'h022);
    push_pulse(9'h033);
    wait_irq("b2b1");
    chk("b2b.d1", 32'(intData), 32'h0011);
    ack_pulse();
    low_gap("b2b1");
    chk("b2b.d2", 32'(intData), 32'h0022);
    ack_pulse();
    low_gap("b2b2");
    chk("b2b.d3", 32'(intData), 32'h0033);
    ack_pulse();
    repeat (4) tick();

    // Overflow: nine pushes, no acknowledge
    for (int i = 0; i < 9; i++) push_pulse(9'h100 + 9'(i));
    chk("ovf.count", 32'(count), 32'd8);
    chk("ovf.flag", 32'(overflow), 32'd1);
    clrOverflow = 1'b1;
    tick();
    clrOverflow = 1'b0;
    chk("ovf.clear", 32'(overflow), 32'd0);
    drain();

    // Simultaneous push and pop
    push_pulse(9'h031);
    push_pulse(9'h032);
    push_pulse(9'h033);
    wait_irq("simul");
    ack        = 1'b1;
    pressed    = 1'b1;
    pressedKey = 9'h034;
    tick();
    chk("simul.count", 32'(count), 32'd3);
    ack     = 1'b0;
    pressed = 1'b0;
    tick();
    for (int i = 0; i < 20; i++) begin
      wait_irq("wrap");
      ack        = 1'b1;
      pressed    = 1'b1;
      pressedKey = 9'($urandom);
      tick();
      ack     = 1'b0;
      pressed = 1'b0;
      tick();
    end
    chk("wrap.count", 32'(count), 32'd3);
    drain();

    // Held and ignored inputs
    pressedKey = 9'h055;
    pressed    = 1'b1;
    repeat (10) tick();
    pressed = 1'b0;
    tick();
    chk("held_press.count", 32'(count), 32'd1);
    wait_irq("held");
    ack = 1'b1;
    repeat (5) tick();
    ack = 1'b0;
    tick();
    chk("held_ack.count", 32'(count), 32'd0);
    enable = 1'b0;
    push_pulse(9'h066);
    chk("disabled.count", 32'(count), 32'd0);
    enable = 1'b1;
    repeat (4) tick();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      pressed     = ($urandom_range(0, 3) == 0);
      pressedKey  = 9'($urandom);
      enable      = ($urandom_range(0, 7) != 0);
      ack         = (i < 200) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 2) == 0);
      clrOverflow = ($urandom_range(0, 15) == 0);
      tick();
    end
    pressed     = 1'b0;
    ack         = 1'b0;
    clrOverflow = 1'b0;
    enable      = 1'b1;
    tick();
    drain();

    // Reset while presenting with four queued
    for (int i = 0; i < 4; i++) push_pulse(9'h0C0 + 9'(i));
    wait_irq("midrst");
    chk("midrst.pre_count", 32'(count), 32'd4);
    ack = 1'b1;
    rst = 1'b0;
    #1;
    model_reset();
    check_outputs("midrst.async");
    repeat (2) tick();
    rst = 1'b1;
    repeat (5) tick();
    chk("midrst.after_count", 32'(count), 32'd0);
    chk("midrst.after_irq", 32'(irq), 32'd0);
    ack = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
